display_scan_driver: RTL and testbench

DISPLAY_SCAN_DRIVER -- requirements
Module: display_scan_driver

---
 rtl/display_scan_driver.sv | 209 ++++++++++++++++++++
 tb/tb_display_scan_driver.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/display_scan_driver.sv
// -----------------------------------------------------------------------------
// display_scan_driver
//
// Time-multiplexed driver for a six-digit, common-anode 7-segment clock
// display. Each digit owns one slot of SCAN_DIV clock cycles. A slot starts
// with BLANK_CYC cycles where every anode is off, which hides ghosting while
// the segment lines change. The rest of the slot drives the digit.
//
// All display inputs are sampled once per frame, at the start of slot 0.
// Every digit in that frame therefore comes from one coherent time value,
// even if the time source updates part way through the scan.
//
// Parameters
//   SCAN_DIV  : clk cycles per digit slot (>= 4)
//   BLANK_CYC : blanking cycles at the start of each slot (1 .. SCAN_DIV-1)
//   BLINK_DIV : clk cycles per blink half-period (>= 2)
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   res        : synchronous reset, active-low
//   DIG0..DIG5 : BCD digits, DIG0 = seconds units .. DIG5 = hours tens
//   lz_en      : blank DIG5 when it is zero (leading-zero suppression)
//   dp_mask    : bit i lights the decimal point of digit i
//   blink_mask : bit i blinks digit i (time-set indication)
//   seg        : {g,f,e,d,c,b,a}, active-low, registered
//   dp         : decimal point, active-low, registered
//   an         : digit enables, active-low, an[i] selects digit i, registered
// -----------------------------------------------------------------------------
module display_scan_driver #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       res,
  input  logic [3:0] DIG0,
  input  logic [3:0] DIG1,
  input  logic [3:0] DIG2,
  input  logic [3:0] DIG3,
  input  logic [3:0] DIG4,
  input  logic [3:0] DIG5,
  input  logic       lz_en,
  input  logic [5:0] dp_mask,
  input  logic [5:0] blink_mask,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an
);

  localparam int C_W = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int B_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [C_W-1:0] C_LAST = C_W'(SCAN_DIV - 1);
  localparam logic [B_W-1:0] B_LAST = B_W'(BLINK_DIV - 1);
  localparam logic [2:0]     K_LAST = 3'd5;

  // Per-slot state. It is derived from the slot counter, but it is kept as
  // its own register so the output stage only needs one bit.
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } slot_state_t;

  // ---------------------------------------------------------------------------
  // 7-segment decode, active-low {g,f,e,d,c,b,a}. Non-BCD codes stay dark.
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] decode7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic [C_W-1:0]  c_q, c_d;               // cycle within slot
  logic [2:0]      k_q, k_d;               // digit index 0..5
  slot_state_t     state_q, state_d;
  logic [B_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic            phase_q, phase_d;       // 1 = blinking digits dark

  logic [5:0][3:0] dig_snap_q, dig_snap_d;
  logic            lz_snap_q, lz_snap_d;
  logic [5:0]      dp_snap_q, dp_snap_d;
  logic [5:0]      blink_snap_q, blink_snap_d;

  logic [5:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  // Internal combinational terms
  logic            c_last;
  logic            frame_start;
  logic [5:0][3:0] dig_in;
  logic [3:0]      cur_dig;
  logic            lit;
  logic            lz_blank;

  assign dig_in = {DIG5, DIG4, DIG3, DIG2, DIG1, DIG0};

  // ---------------------------------------------------------------------------
  // Scan position and blink timebase
  // ---------------------------------------------------------------------------
  always_comb begin
    c_last      = (c_q == C_LAST);
    c_d         = c_last ? '0 : c_q + 1'b1;
    k_d         = k_q;
    if (c_last) begin
      k_d = (k_q == K_LAST) ? 3'd0 : k_q + 3'd1;
    end
    // State for the cycle that c_d will describe
    state_d     = (int'(c_d) < BLANK_CYC) ? ST_BLANK : ST_DRIVE;

    // The blink timebase runs freely and is independent of the scan
    blink_cnt_d = (blink_cnt_q == B_LAST) ? '0 : blink_cnt_q + 1'b1;
    phase_d     = (blink_cnt_q == B_LAST) ? ~phase_q : phase_q;
  end

  // ---------------------------------------------------------------------------
  // Frame snapshot: the inputs are latched only at slot 0, cycle 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    frame_start  = (c_q == '0) && (k_q == 3'd0);
    dig_snap_d   = dig_snap_q;
    lz_snap_d    = lz_snap_q;
    dp_snap_d    = dp_snap_q;
    blink_snap_d = blink_snap_q;
    if (frame_start) begin
      dig_snap_d   = dig_in;
      lz_snap_d    = lz_en;
      dp_snap_d    = dp_mask;
      blink_snap_d = blink_mask;
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage. This is computed from the current (c,k) and registered, so
  // the pins lag the scan position by one cycle. Cycle 0 of every slot is
  // always BLANK, so using the snapshot value from before this edge never
  // exposes stale data.
  // ---------------------------------------------------------------------------
  always_comb begin
    cur_dig  = dig_snap_q[k_q];
    lit      = (state_q == ST_DRIVE) && !(phase_q && blink_snap_q[k_q]);
    // Leading-zero suppression keeps the anode scanning but darkens the digit
    lz_blank = (k_q == K_LAST) && lz_snap_q && (cur_dig == 4'd0);

    an_d  = 6'b111111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (lit) begin
      an_d = ~(6'b000001 << k_q);
      if (!lz_blank) begin
        seg_d = decode7(cur_dig);
        dp_d  = ~dp_snap_q[k_q];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!res) begin
      c_q          <= '0;
      k_q          <= 3'd0;
      state_q      <= ST_BLANK;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      dig_snap_q   <= '0;
      lz_snap_q    <= 1'b0;
      dp_snap_q    <= '0;
      blink_snap_q <= '0;
      an_q         <= 6'b111111;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
    end else begin
      c_q          <= c_d;
      k_q          <= k_d;
      state_q      <= state_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      dig_snap_q   <= dig_snap_d;
      lz_snap_q    <= lz_snap_d;
      dp_snap_q    <= dp_snap_d;
      blink_snap_q <= blink_snap_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_display_scan_driver
//
// Directed testbench for display_scan_driver with a small configuration:
// SCAN_DIV=8, BLANK_CYC=2, BLINK_DIV=64. The cycle counter cyc counts clock
// edges since reset release. Output cycle n shows scan position n-1:
// c = (n-1)%8, k = ((n-1)/8)%6, blink phase = ((n-1)/64)%2.
// The bench compares the packed value {an, seg, dp} with hand-computed
// constants.
// -----------------------------------------------------------------------------
module tb_display_scan_driver;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic [3:0] d0, d1, d2, d3, d4, d5;
  logic       lz_en;
  logic [5:0] dp_mask;
  logic [5:0] blink_mask;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int onehot_bad = 0;
  int dark_bad   = 0;
  bit mon_en   = 1'b0;

  localparam logic [13:0] DARK = 14'h3FFF;

  display_scan_driver #(
    .SCAN_DIV (8),
    .BLANK_CYC(2),
    .BLINK_DIV(64)
  ) dut (
    .clk       (clk),
    .res       (res),
    .DIG0      (d0),
    .DIG1      (d1),
    .DIG2      (d2),
    .DIG3      (d3),
    .DIG4      (d4),
    .DIG5      (d5),
    .lz_en     (lz_en),
    .dp_mask   (dp_mask),
    .blink_mask(blink_mask),
    .seg       (seg),
    .dp        (dp),
    .an        (an)
  );

  always #5 clk = ~clk;

  // Continuous invariants: at most one anode is on, and a dark display
  // has dark segments.
  always @(negedge clk) begin
    if (mon_en) begin
      if ($countones(~an) > 1) onehot_bad++;
      if ((an == 6'b111111) && ((seg != 7'b1111111) || (dp != 1'b1))) dark_bad++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end else begin
      $display("ok   %s cyc=%0d got=%h", tag, cyc, got);
    end
  endtask

  function automatic logic [31:0] obs();
    return {18'd0, an, seg, dp};
  endfunction

  function automatic logic [31:0] exp_v(input logic [5:0] a, input logic [6:0] s, input logic p);
    return {18'd0, a, s, p};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  // Holds reset for two edges, checks the idle outputs, then releases.
  // The next edge becomes cycle 1 (slot 0, c=0).
  task automatic do_reset(input string tag);
    res = 1'b0;
    repeat (2) step();
    mon_en = 1'b1;
    chk(tag, obs(), exp_v(6'b111111, 7'b1111111, 1'b1));
    res = 1'b1;
    cyc = 0;
  endtask

  task automatic set_digits(input logic [3:0] v5, input logic [3:0] v4, input logic [3:0] v3,
                            input logic [3:0] v2, input logic [3:0] v1, input logic [3:0] v0);
    d5 = v5; d4 = v4; d3 = v3; d2 = v2; d1 = v1; d0 = v0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    lz_en = 1'b0; dp_mask = 6'b000000; blink_mask = 6'b000000;

    // Basic scan, latency, blank window and frame snapshot
    do_reset("rst_a");
    run_to(1);  chk("a_c0_blank",  obs(), DARK);
    run_to(2);  chk("a_c1_blank",  obs(), DARK);
    run_to(3);  chk("a_d0_first",  obs(), exp_v(6'b111110, 7'b0000010, 1'b1));
    run_to(8);  chk("a_d0_last",   obs(), exp_v(6'b111110, 7'b0000010, 1'b1));
    run_to(9);  chk("a_k1_blank",  obs(), DARK);
    run_to(10);
    d0 = 4'd9; d1 = 4'd7;                       // changes mid-frame
    run_to(11); chk("a_d1_snap",   obs(), exp_v(6'b111101, 7'b0010010, 1'b1));
    run_to(43); chk("a_d5_first",  obs(), exp_v(6'b011111, 7'b1111001, 1'b1));
    run_to(48); chk("a_d5_last",   obs(), exp_v(6'b011111, 7'b1111001, 1'b1));
    run_to(49); chk("a_f1_blank",  obs(), DARK);
    run_to(51); chk("a_f1_d0_9",   obs(), exp_v(6'b111110, 7'b0010000, 1'b1));
    run_to(59); chk("a_f1_d1_7",   obs(), exp_v(6'b111101, 7'b1111000, 1'b1));

    // Leading-zero suppression, with the dp on digit 5 requested
    set_digits(4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    lz_en = 1'b1; dp_mask = 6'b100000;
    do_reset("rst_b");
    run_to(35); chk("b_d4",        obs(), exp_v(6'b101111, 7'b0100100, 1'b1));
    run_to(43); chk("b_lz_on",     obs(), exp_v(6'b011111, 7'b1111111, 1'b1));
    lz_en = 1'b0;
    do_reset("rst_b2");
    run_to(43); chk("b_lz_off",    obs(), exp_v(6'b011111, 7'b1000000, 1'b0));

    // Blink on digits 4 and 5
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    lz_en = 1'b0; dp_mask = 6'b000000; blink_mask = 6'b110000;
    do_reset("rst_c");
    run_to(35);  chk("c_d4_ph0",   obs(), exp_v(6'b101111, 7'b0100100, 1'b1));
    run_to(43);  chk("c_d5_ph0",   obs(), exp_v(6'b011111, 7'b1111001, 1'b1));
    run_to(67);  chk("c_d2_ph1",   obs(), exp_v(6'b111011, 7'b0011001, 1'b1));
    run_to(83);  chk("c_d4_ph1",   obs(), DARK);
    run_to(91);  chk("c_d5_ph1",   obs(), DARK);
    run_to(99);  chk("c_d0_ph1",   obs(), exp_v(6'b111110, 7'b0000010, 1'b1));
    run_to(131); chk("c_d4_ph0b",  obs(), exp_v(6'b101111, 7'b0100100, 1'b1));

    // Non-BCD code with a decimal point
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'hC);
    blink_mask = 6'b000000; dp_mask = 6'b000001;
    do_reset("rst_d");
    run_to(3);  chk("d_hexc_dp",   obs(), exp_v(6'b111110, 7'b1111111, 1'b0));
    run_to(11); chk("d_d1_nodp",   obs(), exp_v(6'b111101, 7'b0010010, 1'b1));

    // Reset pulse at slot 3, c=5
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    dp_mask = 6'b000000;
    do_reset("rst_e");
    run_to(29); chk("e_d3_pre",    obs(), exp_v(6'b110111, 7'b0110000, 1'b1));
    res = 1'b0;
    step();     chk("e_rst_dark",  obs(), DARK);
    res = 1'b1;
    cyc = 0;
    run_to(2);  chk("e_rel_blank", obs(), DARK);
    run_to(3);  chk("e_rescan_d0", obs(), exp_v(6'b111110, 7'b0000010, 1'b1));
    run_to(11); chk("e_rescan_d1", obs(), exp_v(6'b111101, 7'b0010010, 1'b1));

    chk("onehot_an",  onehot_bad, 0);
    chk("dark_seg",   dark_bad,   0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
